// File: rtl/rep_sequencer_if.sv
// Handshake bundle between the repeat sequencer, its requester, the CX counter
// and the execution unit.
interface rep_sequencer_if;
  logic       start;
  logic [7:0] count_in;
  logic       abort;
  logic       step_done;
  logic       cx_iszero;
  logic [7:0] cx_in;
  logic       cx_load_enable;
  logic       cx_count_enable;
  logic       step_req;
  logic       busy;
  logic       done;
  logic [1:0] status;
  logic [7:0] steps_done;

  modport master (
    output start, count_in, abort, step_done, cx_iszero,
    input  cx_in, cx_load_enable, cx_count_enable, step_req, busy, done, status, steps_done
  );

  modport slave (
    input  start, count_in, abort, step_done, cx_iszero,
    output cx_in, cx_load_enable, cx_count_enable, step_req, busy, done, status, steps_done
  );
endinterface

// File: rtl/rep_sequencer.sv
// Repeat-string sequencer: loads CX, then issues one step per CX count until
// CX reaches zero, an abort arrives, or a step times out.
module rep_sequencer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           reset,
  rep_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_TEST, S_STEP, S_DEC, S_FINISH
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     r_state, w_next;
  logic [7:0] r_cx_in, r_steps, r_tcnt;
  logic [1:0] r_status;
  logic       w_abort_act, w_step_ok, w_tmo;

  assign w_abort_act = bus.abort && (r_state inside {S_LOAD, S_TEST, S_STEP, S_DEC});
  // abort outranks both step_done and timeout in the same STEP cycle
  assign w_step_ok   = (r_state == S_STEP) && bus.step_done && !bus.abort;
  assign w_tmo       = (r_state == S_STEP) && !bus.step_done && !bus.abort && (r_tcnt == TMO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.start) w_next = S_LOAD;
      S_LOAD:   w_next = S_TEST;
      S_TEST:   w_next = bus.cx_iszero ? S_FINISH : S_STEP;
      S_STEP:   if (bus.step_done) w_next = S_DEC;
                else if (w_tmo)    w_next = S_FINISH;
      S_DEC:    w_next = S_TEST;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (w_abort_act) w_next = S_FINISH;
  end

  always_comb begin
    bus.cx_load_enable  = 1'b0;
    bus.cx_count_enable = 1'b0;
    bus.step_req        = 1'b0;
    bus.done            = 1'b0;
    bus.busy            = (r_state != S_IDLE);
    case (r_state)
      S_LOAD:   bus.cx_load_enable  = 1'b1;
      S_STEP:   bus.step_req        = 1'b1;
      S_DEC:    bus.cx_count_enable = 1'b1;
      S_FINISH: bus.done            = 1'b1;
      default:  ;
    endcase
  end

  // timeout counter restarts in TEST, which is the only way into STEP
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cx_in  <= 8'd0;
      r_steps  <= 8'd0;
      r_tcnt   <= 8'd0;
      r_status <= 2'b00;
    end else begin
      if (r_state == S_IDLE && bus.start) begin
        r_cx_in  <= bus.count_in;
        r_steps  <= 8'd0;
        r_status <= 2'b00;
      end
      if (r_state == S_TEST)                         r_tcnt <= 8'd0;
      else if (r_state == S_STEP && !bus.step_done) r_tcnt <= r_tcnt + 8'd1;
      if (w_step_ok) r_steps <= r_steps + 8'd1;
      if (w_abort_act) r_status <= 2'b01;
      else if (w_tmo)  r_status <= 2'b10;
    end
  end

  assign bus.cx_in      = r_cx_in;
  assign bus.steps_done = r_steps;
  assign bus.status     = r_status;

endmodule

// File: doc/rep_sequencer.md
REP_SEQUENCER -- requirements
Module: rep_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 64, legal 1..255: maximum cycles STEP waits for step_done before aborting with timeout.
REQ-002 clk  input  1  clock; all state changes on posedge clk.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a repeat sequence; sampled only in IDLE.
REQ-005 count_in  input  8  repeat count, captured on accepted start.
REQ-006 abort  input  1  terminate the active sequence.
REQ-007 step_done  input  1  execution unit completed the current step.
REQ-008 cx_iszero  input  1  zero flag from the CX down-counter.
REQ-009 cx_in  output  8  load value for CX; equals the captured count.
REQ-010 cx_load_enable  output  1  one-cycle CX load strobe.
REQ-011 cx_count_enable  output  1  one-cycle CX decrement strobe.
REQ-012 step_req  output  1  request one step from the execution unit.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle end-of-sequence pulse.
REQ-015 status  output  2  00 ok, 01 aborted, 10 timeout; 11 never driven.
REQ-016 steps_done  output  8  steps accepted in the current or last sequence.

Function
REQ-017 FSM states IDLE, LOAD, TEST, STEP, DEC, FINISH; registered state, Moore-decoded strobes.
REQ-018 IDLE: start=1 -> capture count_in into cx_in, clear steps_done and status, go to LOAD; start outside IDLE ignored.
REQ-019 LOAD: cx_load_enable=1 exactly one cycle -> TEST.
REQ-020 TEST: cx_iszero=1 -> FINISH; else -> STEP; TEST lasts one cycle.
REQ-021 STEP: step_req=1 held until step_done sampled high; then steps_done increments by 1 (mod 256) -> DEC.
REQ-022 STEP: timeout counter cleared on entry, increments each STEP cycle without step_done; reaching TIMEOUT -> status=10, FINISH, no increment, no decrement.
REQ-023 DEC: cx_count_enable=1 exactly one cycle -> TEST.
REQ-024 FINISH: done=1 one cycle -> IDLE; status and steps_done held until next accepted start.
REQ-025 abort=1 in LOAD, TEST, STEP or DEC -> status=01, next state FINISH, no strobe in the following cycle; ignored in IDLE and FINISH.
REQ-026 abort and step_done in same STEP cycle: abort wins; steps_done unchanged, no DEC.
REQ-027 cx_load_enable and cx_count_enable never high in the same cycle; neither high outside LOAD/DEC.
REQ-028 count_in=0: done asserts in third cycle after start edge (LOAD, TEST, FINISH), steps_done=0, zero step_req.
REQ-029 count_in=N, single-cycle step_done: N iterations of TEST/STEP/DEC, total busy cycles 3N+3.
REQ-030 start held high across FINISH->IDLE begins a new sequence on the first IDLE cycle.

Reset
REQ-031 reset low -> immediately state IDLE; cx_in=0, cx_load_enable=0, cx_count_enable=0, step_req=0, busy=0, done=0, status=00, steps_done=0, timeout counter=0.
REQ-032 Reset mid-sequence discards all progress; no done pulse produced; first start after release behaves as from power-up.

Verification
REQ-033 start, count_in=3, step_done returned 1 cycle after each step_req -> 1 load strobe, 3 step_req, 3 count strobes, done with status=00, steps_done=3.
REQ-034 start, count_in=0 -> load strobe, no step_req, done on 3rd cycle after start, steps_done=0.
REQ-035 count_in=5, abort asserted during 2nd STEP -> no further strobes, done next cycle, status=01, steps_done=1.
REQ-036 TIMEOUT=4, count_in=2, step_done never returned -> step_req high 4 cycles, done, status=10, steps_done=0, no count strobe.
REQ-037 count_in=4, reset pulsed low during DEC -> all outputs zero at once; new start with count_in=1 completes with steps_done=1.
REQ-038 start re-asserted while busy with count_in=9 -> ignored; cx_in keeps original value through completion.
